serializer_stream: RTL

//  Parametrised successor serializer: buffers parallel words in an internal FIFO and emits them bit-serially.

---
 rtl/serializer_stream.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/serializer_stream.sv
// Word-to-bit serializer behind a small {data,len} FIFO; first bit valid one edge after the word is
// accepted into an empty block; ser_rdy_i low freezes the serial outputs, data_rdy_o drops only when full.
module serializer_stream #(
    parameter int DATA_BUS_WIDTH = 16,
    parameter int DATA_MOD_WIDTH = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter bit MSB_FIRST      = 1'b1,
    parameter int MIN_LEN        = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [DATA_BUS_WIDTH-1:0]     data_i,
    input  logic [DATA_MOD_WIDTH-1:0]     data_mod_i,
    input  logic                          data_val_i,
    output logic                          data_rdy_o,
    output logic                          ser_data_o,
    output logic                          ser_data_val_o,
    output logic                          ser_last_o,
    input  logic                          ser_rdy_i,
    output logic                          busy_o,
    output logic                          drop_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

    localparam int W  = DATA_BUS_WIDTH;
    localparam int LW = DATA_MOD_WIDTH + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [LW-1:0] FULL_LEN  = LW'(W);
    localparam logic [LW-1:0] MIN_LEN_V = LW'(MIN_LEN);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    typedef struct packed {
        logic [W-1:0]  dat;
        logic [LW-1:0] len;
    } entry_t;

    state_t        state_q, state_d;
    entry_t        mem_q [FIFO_DEPTH];
    entry_t        wr_entry;
    entry_t        rd_entry;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [W-1:0]  sreg_q, sreg_d;
    logic [LW-1:0] bit_cnt_q, bit_cnt_d;
    logic          drop_q, drop_d;
    logic          alive_q, alive_d;
    logic [LW-1:0] in_len;
    logic          accept, short_frame, wr_en, pop, fifo_empty, last_bit;

    // alive_q keeps data_rdy_o low through reset and the first edge after release
    assign alive_d    = 1'b1;
    assign fifo_empty = (fifo_cnt_q == '0);
    assign rd_entry   = mem_q[rd_ptr_q];
    assign data_rdy_o = alive_q & (fifo_cnt_q != FULL_CNT);
    assign fifo_cnt_o = fifo_cnt_q;
    assign drop_o     = drop_q;

    always_comb begin
        in_len       = (data_mod_i == '0) ? FULL_LEN : {1'b0, data_mod_i};
        short_frame  = (in_len < MIN_LEN_V);
        accept       = data_val_i & data_rdy_o;
        wr_en        = accept & ~short_frame;
        drop_d       = accept & short_frame;
        wr_entry.dat = data_i;
        wr_entry.len = in_len;
        wr_ptr_d     = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
        fifo_cnt_d   = fifo_cnt_q;
        case ({wr_en, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = SHIFT;
            SHIFT:   if (ser_rdy_i && last_bit && fifo_empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A frame's last bit and the next frame's load share one edge, so frames abut without a gap
    always_comb begin
        last_bit  = (state_q == SHIFT) && (bit_cnt_q == '0);
        pop       = !fifo_empty && ((state_q == IDLE) || (ser_rdy_i && last_bit));
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        if (pop) begin
            sreg_d    = rd_entry.dat;
            bit_cnt_d = rd_entry.len - LW'(1);
        end else if ((state_q == SHIFT) && ser_rdy_i) begin
            if (last_bit) begin
                sreg_d    = '0;
                bit_cnt_d = '0;
            end else begin
                sreg_d    = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
                bit_cnt_d = bit_cnt_q - LW'(1);
            end
        end
        ser_data_val_o = (state_q == SHIFT);
        ser_last_o     = last_bit;
        ser_data_o     = ser_data_val_o & (MSB_FIRST ? sreg_q[W-1] : sreg_q[0]);
        busy_o         = ser_data_val_o | !fifo_empty;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            sreg_q     <= '0;
            bit_cnt_q  <= '0;
            drop_q     <= 1'b0;
            alive_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            sreg_q     <= sreg_d;
            bit_cnt_q  <= bit_cnt_d;
            drop_q     <= drop_d;
            alive_q    <= alive_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

endmodule
